// File: rtl/lagtester_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lagtester_pkg
// Brief    : Shared measurement-scheduler state encoding and default constants.
// Revision : 1.0
// ============================================================================
package lagtester_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_SETTLE     = 3'd1,
        ST_WAIT_FRAME = 3'd2,
        ST_MEASURE    = 3'd3,
        ST_HOLDOFF    = 3'd4,
        ST_DONE       = 3'd5
    } meas_state_t;

    localparam int SETTLE_FRAMES_DEF  = 8;
    localparam int TIMEOUT_CYCLES_DEF = 27000000;
    localparam int SAMPLES_DEF        = 16;

    // A round is in progress anywhere between leaving IDLE and reaching DONE.
    function automatic logic is_busy(input meas_state_t s);
        return (s == ST_SETTLE) || (s == ST_WAIT_FRAME) ||
               (s == ST_MEASURE) || (s == ST_HOLDOFF);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_level.sv
`default_nettype none
// ============================================================================
// Module   : sync_level
// Brief    : Two-flop synchronizer for a slow asynchronous level signal.
// Revision : 1.0
// ============================================================================
module sync_level (
    input  logic clock,
    input  logic reset_n,
    input  logic i_level,
    output logic o_level
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_level;
            r_sync <= r_meta;
        end
    end

    assign o_level = r_sync;

endmodule
`default_nettype wire

// File: rtl/measure_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : measure_scheduler
// Brief    : Sequences lag-measurement rounds: lock, settle, per-frame arming,
//            sample collection with timeout, round completion.
// Revision : 1.0
// ============================================================================
module measure_scheduler
    import lagtester_pkg::*;
#(
    parameter int SETTLE_FRAMES  = SETTLE_FRAMES_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int SAMPLES        = SAMPLES_DEF,
    parameter int TMR_W          = 25,
    parameter int CNT_W          = 5
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             pll_locked,
    input  logic             frame_start,
    input  logic             sensor_trigger,
    input  logic             config_changed,
    output logic             reset_counter,
    output logic             sample_valid,
    output logic             sample_timeout,
    output logic [CNT_W-1:0] sample_count,
    output logic [CNT_W-1:0] timeout_count,
    output logic             busy,
    output logic             round_done
);

    localparam int                 c_set_w       = (SETTLE_FRAMES > 1) ? $clog2(SETTLE_FRAMES) : 1;
    localparam logic [c_set_w-1:0] c_settle_last = c_set_w'((SETTLE_FRAMES > 0) ? SETTLE_FRAMES - 1 : 0);
    localparam logic [TMR_W-1:0]   c_tmr_last    = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]   c_samples     = CNT_W'(SAMPLES);
    localparam logic [CNT_W-1:0]   c_cnt_max     = '1;

    logic w_locked;

    meas_state_t        r_state;
    logic [c_set_w-1:0] r_settle_cnt;
    logic [TMR_W-1:0]   r_timer;
    logic [CNT_W-1:0]   r_sample_cnt;
    logic [CNT_W-1:0]   r_timeout_cnt;
    logic               r_reset_counter;
    logic               r_sample_valid;
    logic               r_sample_timeout;
    logic               r_busy;
    logic               r_round_done;

    meas_state_t        w_state_nxt;
    logic [c_set_w-1:0] w_settle_nxt;
    logic [TMR_W-1:0]   w_timer_nxt;
    logic [CNT_W-1:0]   w_sample_nxt;
    logic [CNT_W-1:0]   w_timeout_nxt;
    logic               w_rc_nxt;
    logic               w_sv_nxt;
    logic               w_st_nxt;

    sync_level u_lock_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .i_level (pll_locked),
        .o_level (w_locked)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_settle_nxt  = r_settle_cnt;
        w_timer_nxt   = r_timer;
        w_sample_nxt  = r_sample_cnt;
        w_timeout_nxt = r_timeout_cnt;
        w_rc_nxt      = 1'b0;
        w_sv_nxt      = 1'b0;
        w_st_nxt      = 1'b0;

        if (r_state == ST_IDLE) begin
            if (w_locked) begin
                w_state_nxt   = ST_SETTLE;
                w_settle_nxt  = '0;
                w_timer_nxt   = '0;
                w_sample_nxt  = '0;
                w_timeout_nxt = '0;
            end
        end else if (!w_locked || config_changed) begin
            // Lock loss outranks a config change; both abandon the round and
            // leave every pulse at its default of zero.
            w_state_nxt   = w_locked ? ST_SETTLE : ST_IDLE;
            w_settle_nxt  = '0;
            w_timer_nxt   = '0;
            w_sample_nxt  = '0;
            w_timeout_nxt = '0;
        end else begin
            case (r_state)
                ST_SETTLE: begin
                    if (SETTLE_FRAMES == 0) begin
                        w_state_nxt = ST_WAIT_FRAME;
                    end else if (frame_start) begin
                        if (r_settle_cnt == c_settle_last) begin
                            w_state_nxt  = ST_WAIT_FRAME;
                            w_settle_nxt = '0;
                        end else begin
                            w_settle_nxt = r_settle_cnt + 1'b1;
                        end
                    end
                end
                ST_WAIT_FRAME: begin
                    if (frame_start) begin
                        w_state_nxt = ST_MEASURE;
                        w_rc_nxt    = 1'b1;
                        w_timer_nxt = '0;
                    end
                end
                ST_MEASURE: begin
                    w_timer_nxt = r_timer + 1'b1;
                    if (sensor_trigger) begin
                        w_sv_nxt    = 1'b1;
                        w_state_nxt = ST_HOLDOFF;
                        if (r_sample_cnt != c_samples) begin
                            w_sample_nxt = r_sample_cnt + 1'b1;
                        end
                    end else if (r_timer == c_tmr_last) begin
                        w_st_nxt    = 1'b1;
                        w_state_nxt = ST_HOLDOFF;
                        if (r_timeout_cnt != c_cnt_max) begin
                            w_timeout_nxt = r_timeout_cnt + 1'b1;
                        end
                    end
                end
                ST_HOLDOFF: begin
                    if (frame_start) begin
                        w_state_nxt = (r_sample_cnt == c_samples) ? ST_DONE : ST_WAIT_FRAME;
                    end
                end
                ST_DONE: begin
                    w_state_nxt = ST_DONE;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state          <= ST_IDLE;
            r_settle_cnt     <= '0;
            r_timer          <= '0;
            r_sample_cnt     <= '0;
            r_timeout_cnt    <= '0;
            r_reset_counter  <= 1'b0;
            r_sample_valid   <= 1'b0;
            r_sample_timeout <= 1'b0;
            r_busy           <= 1'b0;
            r_round_done     <= 1'b0;
        end else begin
            r_state          <= w_state_nxt;
            r_settle_cnt     <= w_settle_nxt;
            r_timer          <= w_timer_nxt;
            r_sample_cnt     <= w_sample_nxt;
            r_timeout_cnt    <= w_timeout_nxt;
            r_reset_counter  <= w_rc_nxt;
            r_sample_valid   <= w_sv_nxt;
            r_sample_timeout <= w_st_nxt;
            r_busy           <= is_busy(w_state_nxt);
            r_round_done     <= (w_state_nxt == ST_DONE);
        end
    end

    assign reset_counter  = r_reset_counter;
    assign sample_valid   = r_sample_valid;
    assign sample_timeout = r_sample_timeout;
    assign sample_count   = r_sample_cnt;
    assign timeout_count  = r_timeout_cnt;
    assign busy           = r_busy;
    assign round_done     = r_round_done;

endmodule
`default_nettype wire

// File: tb/tb_measure_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_measure_scheduler
// Brief    : Directed bench for measure_scheduler with a per-cycle reference model.
// Revision : 1.0
// ============================================================================
module tb_measure_scheduler;

    localparam int SF  = 2;
    localparam int TO  = 100;
    localparam int NS  = 4;
    localparam int CW  = 5;
    localparam int TW  = 25;
    localparam int GAP = 500;

    logic          clock          = 1'b0;
    logic          reset_n        = 1'b0;
    logic          pll_locked     = 1'b0;
    logic          frame_start    = 1'b0;
    logic          sensor_trigger = 1'b0;
    logic          config_changed = 1'b0;
    logic          reset_counter;
    logic          sample_valid;
    logic          sample_timeout;
    logic [CW-1:0] sample_count;
    logic [CW-1:0] timeout_count;
    logic          busy;
    logic          round_done;

    measure_scheduler #(
        .SETTLE_FRAMES  (SF),
        .TIMEOUT_CYCLES (TO),
        .SAMPLES        (NS),
        .TMR_W          (TW),
        .CNT_W          (CW)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .pll_locked     (pll_locked),
        .frame_start    (frame_start),
        .sensor_trigger (sensor_trigger),
        .config_changed (config_changed),
        .reset_counter  (reset_counter),
        .sample_valid   (sample_valid),
        .sample_timeout (sample_timeout),
        .sample_count   (sample_count),
        .timeout_count  (timeout_count),
        .busy           (busy),
        .round_done     (round_done)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    // Reference model: phases advance on the spec's rules using elapsed-cycle
    // and frame counts; outputs are what must appear after this edge.
    localparam int P_IDLE = 0, P_SETTLE = 1, P_WAIT = 2, P_MEAS = 3, P_HOLD = 4, P_DONE = 5;
    int m_phase = P_IDLE, m_frames = 0, m_elapsed = 0, m_valid = 0, m_lost = 0;
    bit m_q1 = 0, m_q2 = 0, m_lk = 0;
    bit ex_rc = 0, ex_sv = 0, ex_st = 0, ex_busy = 0, ex_done = 0;

    initial forever begin
        @(posedge clock);
        ex_rc = 0; ex_sv = 0; ex_st = 0;
        if (!reset_n) begin
            m_phase = P_IDLE; m_frames = 0; m_elapsed = 0; m_valid = 0; m_lost = 0;
            m_q1 = 0; m_q2 = 0;
        end else begin
            m_lk = m_q2; m_q2 = m_q1; m_q1 = pll_locked;
            if (m_phase == P_IDLE) begin
                if (m_lk) begin
                    m_phase = P_SETTLE; m_frames = 0; m_valid = 0; m_lost = 0;
                end
            end else if (!m_lk || config_changed) begin
                m_phase = m_lk ? P_SETTLE : P_IDLE;
                m_frames = 0; m_valid = 0; m_lost = 0; m_elapsed = 0;
            end else begin
                case (m_phase)
                    P_SETTLE: begin
                        if (frame_start) m_frames++;
                        if (m_frames >= SF) m_phase = P_WAIT;
                    end
                    P_WAIT: if (frame_start) begin
                        m_phase = P_MEAS; ex_rc = 1; m_elapsed = 0;
                    end
                    P_MEAS: begin
                        m_elapsed++;
                        if (sensor_trigger) begin
                            ex_sv = 1; m_phase = P_HOLD;
                            m_valid = (m_valid < NS) ? m_valid + 1 : NS;
                        end else if (m_elapsed == TO) begin
                            ex_st = 1; m_phase = P_HOLD;
                            m_lost = (m_lost < 31) ? m_lost + 1 : 31;
                        end
                    end
                    P_HOLD: if (frame_start) m_phase = (m_valid == NS) ? P_DONE : P_WAIT;
                    default: ;
                endcase
            end
        end
        ex_busy = (m_phase >= P_SETTLE) && (m_phase <= P_HOLD);
        ex_done = (m_phase == P_DONE);
    end

    // Event log shared with the directed checks.
    int rc_count = 0, sv_count = 0, st_count = 0;
    int first_rc_cyc = 0, last_rc_cyc = 0;
    bit chk_vlat = 0, chk_tlat = 0;
    int tq[$];

    initial forever begin
        @(negedge clock);
        chk("reset_counter", reset_counter, ex_rc);
        chk("sample_valid", sample_valid, ex_sv);
        chk("sample_timeout", sample_timeout, ex_st);
        chk("sample_count", sample_count, m_valid);
        chk("timeout_count", timeout_count, m_lost);
        chk("busy", busy, ex_busy);
        chk("round_done", round_done, ex_done);
        chk("pulse_overlap", sample_valid && sample_timeout, 0);
        if (reset_counter) begin
            rc_count++;
            last_rc_cyc = cyc;
            if (rc_count == 1) first_rc_cyc = cyc;
        end
        if (sample_valid) begin
            sv_count++;
            if (chk_vlat) chk("valid_latency", cyc - last_rc_cyc, 100);
        end
        if (sample_timeout) begin
            st_count++;
            tq.push_back(int'(timeout_count));
            if (chk_tlat) chk("timeout_latency", cyc - last_rc_cyc, 100);
        end
    end

    // Stimulus generator: periodic frames, sensor a fixed delay after reset_counter.
    bit frames_en = 0, sens_en = 0;
    int sens_delay = 20, fphase = 0, cd = 0;
    int frame_q[$];

    task automatic run(input int n);
        bit fr, sn;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            fr = frames_en && (fphase == GAP - 1);
            fphase = (fphase + 1) % GAP;
            sn = 0;
            if (cd > 0) begin
                cd--;
                sn = sens_en && (cd == 0);
            end
            if (reset_counter) cd = sens_delay;
            frame_start    = fr;
            sensor_trigger = sn;
            config_changed = 0;
            if (fr) frame_q.push_back(cyc);
        end
    endtask

    task automatic drive(input bit sn, input bit cf);
        @(negedge clock);
        frame_start    = 0;
        sensor_trigger = sn;
        config_changed = cf;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int budget, rc0, sv0, st0;

        repeat (3) @(negedge clock);
        chk("rst_busy", busy, 0);
        chk("rst_round_done", round_done, 0);
        chk("rst_sample_count", sample_count, 0);
        chk("rst_timeout_count", timeout_count, 0);
        chk("rst_reset_counter", reset_counter, 0);
        reset_n    = 1;
        pll_locked = 1;

        // Full round with sensor 20 cycles after each reset_counter.
        frames_en = 1; sens_en = 1; sens_delay = 20;
        rc_count = 0; sv_count = 0; st_count = 0; frame_q.delete();
        run(600);
        chk("t1_busy", busy, 1);
        budget = 0;
        while (!round_done && budget < 6000) begin run(1); budget++; end
        chk("t1_round_done", round_done, 1);
        chk("t1_first_rc_after_3rd_frame", first_rc_cyc - frame_q[2], 1);
        chk("t1_valid_pulses", sv_count, 4);
        chk("t1_sample_count", sample_count, 4);
        chk("t1_timeout_count", timeout_count, 0);
        chk("t1_busy_in_done", busy, 0);

        // DONE ignores frames and sensors until config_changed.
        rc0 = rc_count; sv0 = sv_count; st0 = st_count;
        for (int i = 0; i < 3; i++) begin
            drive(1, 0);
            run(400);
        end
        chk("t6_no_rc", rc_count - rc0, 0);
        chk("t6_no_valid", sv_count - sv0, 0);
        chk("t6_no_timeout", st_count - st0, 0);
        chk("t6_held_count", sample_count, 4);
        chk("t6_still_done", round_done, 1);
        drive(0, 1);
        drive(0, 0);
        chk("t6_done_cleared", round_done, 0);
        chk("t6_busy", busy, 1);
        chk("t6_count_cleared", sample_count, 0);

        // No sensor: every sample times out 100 cycles after reset_counter.
        sens_en = 0; st_count = 0; tq.delete(); chk_tlat = 1;
        budget = 0;
        while (st_count < 3 && budget < 5000) begin run(1); budget++; end
        chk_tlat = 0;
        chk("t2_timeouts", st_count, 3);
        chk("t2_tcount_1", tq[0], 1);
        chk("t2_tcount_2", tq[1], 2);
        chk("t2_tcount_3", tq[2], 3);
        chk("t2_sample_count", sample_count, 0);
        chk("t2_no_done", round_done, 0);

        // Sensor on the very cycle the timeout would fire: sensor wins.
        sens_en = 1; sens_delay = 99; sv_count = 0; chk_vlat = 1;
        budget = 0;
        while (sv_count < 1 && budget < 1500) begin run(1); budget++; end
        chk_vlat = 0;
        sens_en = 0;
        chk("t3_valid_seen", sv_count, 1);
        chk("t3_sample_count", sample_count, 1);
        chk("t3_timeout_count", timeout_count, 3);
        chk("t3_no_timeout", st_count, 3);

        // config_changed plus sensor during MEASURE: sample suppressed, resettle.
        rc0 = rc_count;
        budget = 0;
        while (rc_count == rc0 && budget < 1500) begin run(1); budget++; end
        chk("t4_armed", rc_count - rc0, 1);
        run(10);
        drive(1, 1);
        drive(0, 0);
        chk("t4_no_valid", sample_valid, 0);
        chk("t4_busy", busy, 1);
        chk("t4_sample_count", sample_count, 0);
        chk("t4_timeout_count", timeout_count, 0);
        frame_q.delete();
        sens_en = 1; sens_delay = 20;
        rc0 = rc_count;
        budget = 0;
        while (rc_count == rc0 && budget < 2000) begin run(1); budget++; end
        chk("t4_frames_before_rc", frame_q.size(), 3);
        chk("t4_rc_after_3rd_frame", last_rc_cyc - frame_q[2], 1);

        // Lock loss mid-round.
        run(30);
        chk("t5_pre_count", sample_count, 1);
        drive(0, 0);
        pll_locked = 0;
        repeat (3) drive(0, 0);
        chk("t5_busy_low", busy, 0);
        chk("t5_count_cleared", sample_count, 0);
        chk("t5_no_done", round_done, 0);
        pll_locked = 1;
        run(5);
        chk("t5_restart_busy", busy, 1);
        chk("t5_restart_count", sample_count, 0);
        frame_q.delete(); rc_count = 0;
        budget = 0;
        while (!round_done && budget < 6000) begin run(1); budget++; end
        chk("t5_round_done", round_done, 1);
        chk("t5_sample_count", sample_count, 4);
        chk("t5_first_rc_after_3rd_frame", first_rc_cyc - frame_q[2], 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
